// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD link types and constants
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_RST_LOW  = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_NEXT     = 3'd4
  } lcd_state_t;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// rtl/spi_clk_tick.sv - sclk half-period divider with rise/fall qualified toggle strobe
module spi_clk_tick
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic sclk_now,
  output logic tick,
  output logic tick_rise
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Held at zero while not shifting so every byte starts on a full half-period.
  always_ff @(posedge clk) begin
    if (!reset || !run) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick      = run && (div_cnt == DIV_LAST);
  assign tick_rise = tick && !sclk_now;

endmodule

// File: rtl/lcd_spi_tx.sv
// rtl/lcd_spi_tx.sv - LCD power-on reset sequencer and MSB-first SPI mode 0 byte transmitter
module lcd_spi_tx
  import lcd_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RST_LOW_CYC  = 200,
  parameter int RST_WAIT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_dc,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       init_done,
  output logic       mosi,
  output logic       sclk,
  output logic       cs,
  output logic       dc,
  output logic       lcd_rst
);

  localparam int RST_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int RCW     = cnt_width(RST_MAX);
  localparam logic [RCW-1:0] LOW_LAST  = RCW'(RST_LOW_CYC - 1);
  localparam logic [RCW-1:0] WAIT_LAST = RCW'(RST_WAIT_CYC - 1);

  lcd_state_t     state, state_nx;
  logic [RCW-1:0] rst_cnt, rst_cnt_d;
  logic [2:0]     bit_cnt, bit_cnt_d;
  logic [6:0]     shreg, shreg_d;
  logic           tick, tick_rise, hs, last_fall;
  logic           in_ready_d, init_done_d, mosi_d, sclk_d, cs_d, dc_d, lcd_rst_d;

  spi_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       (state == ST_SHIFT),
    .sclk_now  (sclk),
    .tick      (tick),
    .tick_rise (tick_rise)
  );

  assign hs        = in_valid && in_ready;
  assign last_fall = tick && !tick_rise && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RST_LOW;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RST_LOW:  if (rst_cnt == LOW_LAST) state_nx = ST_RST_WAIT;
      ST_RST_WAIT: if (rst_cnt == WAIT_LAST) state_nx = ST_IDLE;
      ST_IDLE:     if (hs) state_nx = ST_SHIFT;
      ST_SHIFT:    if (last_fall) state_nx = ST_NEXT;
      ST_NEXT:     state_nx = hs ? ST_SHIFT : ST_IDLE;
      default:     state_nx = ST_RST_LOW;
    endcase
  end

  always_comb begin
    rst_cnt_d   = '0;
    bit_cnt_d   = bit_cnt;
    shreg_d     = shreg;
    in_ready_d  = in_ready;
    init_done_d = init_done;
    mosi_d      = mosi;
    sclk_d      = sclk;
    cs_d        = cs;
    dc_d        = dc;
    lcd_rst_d   = lcd_rst;
    unique case (state)
      ST_RST_LOW: begin
        rst_cnt_d = rst_cnt + 1'b1;
        if (rst_cnt == LOW_LAST) begin
          rst_cnt_d = '0;
          lcd_rst_d = 1'b1;
        end
      end
      ST_RST_WAIT: begin
        rst_cnt_d = rst_cnt + 1'b1;
        if (rst_cnt == WAIT_LAST) begin
          rst_cnt_d   = '0;
          init_done_d = 1'b1;
          in_ready_d  = 1'b1;
        end
      end
      ST_IDLE, ST_NEXT: begin
        if (hs) begin
          shreg_d    = in_data[6:0];
          mosi_d     = in_data[7];
          dc_d       = (in_dc == LCD_DATA) ? LCD_DATA : LCD_CMD;
          cs_d       = 1'b0;
          sclk_d     = 1'b0;
          in_ready_d = 1'b0;
          bit_cnt_d  = 3'd0;
        end else if (state == ST_NEXT) begin
          cs_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk;
          // Data moves only on falling sclk so it is stable across the slave's rising sample.
          if (!tick_rise) begin
            if (bit_cnt == 3'd7) begin
              in_ready_d = 1'b1;
            end else begin
              mosi_d    = shreg[6];
              shreg_d   = {shreg[5:0], 1'b0};
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
      mosi      <= 1'b0;
      sclk      <= 1'b0;
      cs        <= 1'b1;
      dc        <= LCD_CMD;
      lcd_rst   <= 1'b0;
    end else begin
      rst_cnt   <= rst_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      in_ready  <= in_ready_d;
      init_done <= init_done_d;
      mosi      <= mosi_d;
      sclk      <= sclk_d;
      cs        <= cs_d;
      dc        <= dc_d;
      lcd_rst   <= lcd_rst_d;
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb/tb_lcd_spi_tx.sv - randomized self-checking bench for lcd_spi_tx with an SPI slave reference model
module tb_lcd_spi_tx;

  localparam int D        = 2;
  localparam int LOWC     = 10;
  localparam int WAITC    = 20;
  localparam int BYTE_CYC = 16 * D + 1;

  typedef struct {
    logic [7:0] b;
    logic       d;
    int         t;
  } xfer_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_dc = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, init_done, mosi, sclk, cs, dc, lcd_rst;

  lcd_spi_tx #(
    .CLK_DIV      (D),
    .RST_LOW_CYC  (LOWC),
    .RST_WAIT_CYC (WAITC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_dc     (in_dc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .init_done (init_done),
    .mosi      (mosi),
    .sclk      (sclk),
    .cs        (cs),
    .dc        (dc),
    .lcd_rst   (lcd_rst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  xfer_t exp_q[$];

  // SPI slave model: samples on rising sclk, judges each byte at its 8th falling sclk.
  logic       p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  logic [7:0] cap = 8'h00;
  int         mon_bits = 0, first_rise = 0, last_rise = 0, shape_bad = 0, dc_bad = 0;
  int         cs_fall = 0, bytes_in_cs = 0, total_rises = 0, bytes_done = 0, stray_sclk = 0;
  xfer_t      mx;

  always @(negedge clk) begin
    if (!reset) begin
      mon_bits  = 0;
      shape_bad = 0;
      dc_bad    = 0;
      p_sclk    = 1'b0;
      p_cs      = 1'b1;
      p_mosi    = 1'b0;
    end else begin
      if (p_cs && !cs) begin
        cs_fall     = cyc;
        bytes_in_cs = 0;
      end
      if (!p_cs && cs) check_eq("cs_low_len", cyc - cs_fall, bytes_in_cs * BYTE_CYC);
      if (cs && sclk) stray_sclk++;
      if (sclk && p_sclk && (mosi !== p_mosi)) shape_bad++;
      if (!p_sclk && sclk) begin
        total_rises++;
        if (mon_bits == 0) first_rise = cyc;
        else if (cyc - last_rise != 2 * D) shape_bad++;
        last_rise = cyc;
        cap = {cap[6:0], mosi};
        mon_bits++;
        if (exp_q.size() > 0 && dc !== exp_q[0].d) dc_bad++;
      end
      if (p_sclk && !sclk) begin
        if (cyc - last_rise != D) shape_bad++;
        if (mon_bits == 8) begin
          check_eq("unexpected_byte", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            check_eq("rx_byte", cap, mx.b);
            check_eq("rx_dc_bad", dc_bad, 0);
            check_eq("first_rise", first_rise - mx.t, D);
            check_eq("last_fall", cyc - mx.t, 16 * D);
            check_eq("sclk_shape", shape_bad, 0);
          end
          bytes_in_cs++;
          bytes_done++;
          mon_bits  = 0;
          shape_bad = 0;
          dc_bad    = 0;
        end
      end
      p_sclk = sclk;
      p_cs   = cs;
      p_mosi = mosi;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic d, output int t);
    xfer_t e;
    in_data  = b;
    in_dc    = d;
    in_valid = 1'b1;
    t = -1;
    for (int n = 0; n < 4 * BYTE_CYC; n++) begin
      if (in_ready) begin
        t   = cyc + 1;
        e.b = b;
        e.d = d;
        e.t = t;
        exp_q.push_back(e);
        step();
        break;
      end
      step();
    end
    check_eq("hs_done", t >= 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 4 * BYTE_CYC; n++) begin
      step();
      if (cs && in_ready && mon_bits == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("idle_reached", ok, 1);
  endtask

  int n_expect = 0;

  task automatic reset_and_init(input bit preload, input logic [7:0] b, input logic d);
    int c0, t_rst, t_done, t_rdy, stray, t;
    reset    = 1'b0;
    in_valid = preload;
    in_data  = b;
    in_dc    = d;
    repeat (3) step();
    check_eq("rst_lcd_rst", lcd_rst, 0);
    check_eq("rst_cs", cs, 1);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_dc", dc, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_init_done", init_done, 0);
    reset  = 1'b1;
    c0     = cyc;
    t_rst  = -1;
    t_done = -1;
    t_rdy  = -1;
    stray  = 0;
    for (int n = 0; n < LOWC + WAITC + 10; n++) begin
      step();
      if (lcd_rst && t_rst < 0) t_rst = cyc;
      if (init_done && t_done < 0) t_done = cyc;
      if (in_ready && t_rdy < 0) t_rdy = cyc;
      if (!cs || sclk) stray++;
      if (init_done) break;
    end
    check_eq("lcd_rst_low_len", t_rst - c0, LOWC);
    check_eq("init_wait_len", t_done - t_rst, WAITC);
    check_eq("ready_with_done", t_rdy, t_done);
    check_eq("init_cs_sclk", stray, 0);
    if (preload) begin
      send(b, d, t);
      n_expect++;
      check_eq("first_hs_edge", t - c0 - 1, LOWC + WAITC);
      in_valid = 1'b0;
      wait_idle();
    end
  endtask

  initial begin
    int t1, t2, r0, tprev;
    bit held, ok;
    logic [7:0] rb;
    logic rd;

    reset_and_init(1'b1, 8'h81, 1'b1);

    send(8'h2A, 1'b0, t1);
    n_expect++;
    in_valid = 1'b0;
    wait_idle();
    check_eq("cmd_dc_held", dc, 0);

    send(8'hA5, 1'b1, t1);
    send(8'h3C, 1'b1, t2);
    n_expect += 2;
    check_eq("b2b_period", t2 - t1, BYTE_CYC);
    in_valid = 1'b0;
    wait_idle();

    r0 = total_rises;
    send(8'h96, 1'b0, t1);
    n_expect++;
    in_valid = 1'b0;
    repeat (5) step();
    in_data  = 8'h55;
    in_dc    = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_idle();
    check_eq("ignored_pulse_rises", total_rises - r0, 8);

    held  = 1'b0;
    tprev = 0;
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom);
      rd = 1'($urandom);
      if (!held) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
      send(rb, rd, t1);
      n_expect++;
      if (held) check_eq("rand_b2b_period", t1 - tprev, BYTE_CYC);
      tprev = t1;
      held  = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    wait_idle();

    r0 = total_rises;
    send(8'hFF, 1'b1, t1);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 4 * BYTE_CYC; n++) begin
      if (total_rises == r0 + 4) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check_eq("reached_pulse4", ok, 1);
    reset = 1'b0;
    step();
    check_eq("abort_cs", cs, 1);
    check_eq("abort_sclk", sclk, 0);
    check_eq("abort_lcd_rst", lcd_rst, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_init_done", init_done, 0);
    exp_q.delete();

    reset_and_init(1'b0, 8'h00, 1'b0);
    send(8'hC3, 1'b1, t1);
    n_expect++;
    in_valid = 1'b0;
    wait_idle();

    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("bytes_done", bytes_done, n_expect);
    check_eq("sclk_outside_cs", stray_sclk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
